pcievdm_ingr_avmm_adapter: RTL and testbench

PCIEVDM_INGR_AVMM_ADAPTER -- requirements
Module: pcievdm_ingr_avmm_adapter

---
 rtl/pcievdm_ingr_pkg.sv | 19 +
 rtl/pcievdm_sat_cnt.sv | 20 ++
 rtl/pcievdm_ingr_avmm_adapter.sv | 150 +++++++++++++++
 tb/tb_pcievdm_ingr_avmm_adapter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcievdm_ingr_pkg.sv
// Shared types and constants for the SPI-to-VDM-buffer ingress Avalon-MM adapter.
package pcievdm_ingr_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CMD       = 2'd1,
    WAIT_RD   = 2'd2,
    LOCAL_RSP = 2'd3
  } state_t;

  localparam logic [31:0] CSR_W_VERSION = 32'd0;
  localparam logic [31:0] CSR_W_STATUS  = 32'd1;
  localparam logic [31:0] CSR_W_SCRATCH = 32'd2;

  localparam logic [31:0] VERSION   = 32'h0001_0000;
  localparam logic [31:0] REJ_RDATA = 32'hFFFF_FFFF;
  localparam logic [31:0] TMO_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/pcievdm_sat_cnt.sv
// 8-bit event counter that sticks at 8'hFF; clear wins over a same-cycle increment.
module pcievdm_sat_cnt (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 8'h00;
    end else if (clr) begin
      cnt <= 8'h00;
    end else if (inc && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/pcievdm_ingr_avmm_adapter.sv
// Bridges SPI-slave Avalon byte-address commands to the VDM-buffer ingress word slave, with local CSRs.
// Define PCIEVDM_INGR_RD_TIMEOUT_EN to bound the downstream read wait by RD_TIMEOUT_CYCLES.
module pcievdm_ingr_avmm_adapter
  import pcievdm_ingr_pkg::*;
#(
  parameter int INGR_SLV_ADDR_WIDTH = 9,
  parameter int INGR_SLV_CSR_AWIDTH = 4,
  parameter int RD_TIMEOUT_CYCLES   = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [31:0]                    s_addr,
  input  logic                           s_write,
  input  logic                           s_read,
  input  logic [3:0]                     s_byteen,
  input  logic [31:0]                    s_wrdata,
  output logic [31:0]                    s_rddata,
  output logic                           s_rddvld,
  output logic                           s_waitreq,
  output logic [INGR_SLV_ADDR_WIDTH-1:0] m_addr,
  output logic                           m_write,
  output logic                           m_read,
  output logic [31:0]                    m_wrdata,
  input  logic [31:0]                    m_rddata,
  input  logic                           m_rddvld,
  input  logic                           m_waitreq
);

  state_t      state, state_nxt;
  logic        rej, is_csr, accept, local_rd, fwd, rd_done, tmo_evt;
  logic        rej_inc, cnt_clr, scratch_we;
  logic [31:0] csr_word, csr_rdata, scratch;
  logic [7:0]  rej_cnt, tmo_cnt;
  logic        unused_ok;

  assign rej        = (s_byteen != 4'hF) | (s_read & s_write);
  assign is_csr     = (s_addr[31:INGR_SLV_CSR_AWIDTH] == '0);
  assign accept     = (state == IDLE) & (s_read | s_write);
  assign csr_word   = 32'(s_addr[INGR_SLV_CSR_AWIDTH-1:2]);
  assign local_rd   = accept & s_read & (rej | is_csr);
  assign fwd        = accept & ~rej & ~is_csr;
  assign rd_done    = (state == WAIT_RD) & m_rddvld;
  assign rej_inc    = accept & rej;
  assign cnt_clr    = accept & ~rej & is_csr & s_write & (csr_word == CSR_W_STATUS);
  assign scratch_we = accept & ~rej & is_csr & s_write & (csr_word == CSR_W_SCRATCH);
  assign s_waitreq  = (state != IDLE);
  assign unused_ok  = ^{s_addr[1:0], RD_TIMEOUT_CYCLES};

`ifdef PCIEVDM_INGR_RD_TIMEOUT_EN
  localparam int TW = $clog2(RD_TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_timer;

  // Restarts from zero on every entry into WAIT_RD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_timer <= '0;
    end else if (state != WAIT_RD) begin
      tmo_timer <= '0;
    end else if (!tmo_evt) begin
      tmo_timer <= tmo_timer + TW'(1);
    end
  end

  assign tmo_evt = (state == WAIT_RD) & ~m_rddvld & (tmo_timer == TW'(RD_TIMEOUT_CYCLES - 1));
`else
  assign tmo_evt = 1'b0;
`endif

  pcievdm_sat_cnt u_rej_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (rej_inc),
    .clr     (cnt_clr),
    .cnt     (rej_cnt)
  );

  pcievdm_sat_cnt u_tmo_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (tmo_evt),
    .clr     (cnt_clr),
    .cnt     (tmo_cnt)
  );

  always_comb begin
    csr_rdata = '0;
    case (csr_word)
      CSR_W_VERSION: csr_rdata = VERSION;
      CSR_W_STATUS:  csr_rdata = {16'h0, tmo_cnt, rej_cnt};
      CSR_W_SCRATCH: csr_rdata = scratch;
      default:       csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = fwd ? CMD : (s_read ? LOCAL_RSP : IDLE);
      CMD:       if (!m_waitreq) state_nxt = m_read ? WAIT_RD : IDLE;
      WAIT_RD:   if (rd_done || tmo_evt) state_nxt = IDLE;
      LOCAL_RSP: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_rddata <= '0;
      s_rddvld <= 1'b0;
      m_addr   <= '0;
      m_write  <= 1'b0;
      m_read   <= 1'b0;
      m_wrdata <= '0;
      scratch  <= '0;
    end else begin
      s_rddvld <= 1'b0;
      if (fwd) begin
        m_addr   <= s_addr[INGR_SLV_ADDR_WIDTH+1:2];
        m_wrdata <= s_wrdata;
        m_write  <= s_write;
        m_read   <= s_read;
      end else if ((state == CMD) && !m_waitreq) begin
        m_write <= 1'b0;
        m_read  <= 1'b0;
      end
      if (local_rd) begin
        s_rddvld <= 1'b1;
        s_rddata <= rej ? REJ_RDATA : csr_rdata;
      end else if (rd_done) begin
        s_rddvld <= 1'b1;
        s_rddata <= m_rddata;
      end else if (tmo_evt) begin
        s_rddvld <= 1'b1;
        s_rddata <= TMO_RDATA;
      end
      if (scratch_we) begin
        scratch <= s_wrdata;
      end
    end
  end

endmodule

// File: tb/tb_pcievdm_ingr_avmm_adapter.sv
// Directed and randomized checks of the ingress adapter against a transaction-level model.
module tb_pcievdm_ingr_avmm_adapter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] s_addr = '0;
  logic        s_write = 1'b0;
  logic        s_read = 1'b0;
  logic [3:0]  s_byteen = '0;
  logic [31:0] s_wrdata = '0;
  logic [31:0] s_rddata;
  logic        s_rddvld;
  logic        s_waitreq;
  logic [8:0]  m_addr;
  logic        m_write;
  logic        m_read;
  logic [31:0] m_wrdata;
  logic [31:0] m_rddata = '0;
  logic        m_rddvld = 1'b0;
  logic        m_waitreq = 1'b0;

  int ntests = 0;
  int nfail = 0;

  // Model state: downstream slave memory and the adapter's visible CSR state.
  logic [31:0] mem [512];
  int unsigned mdl_rej = 0;
  int unsigned mdl_tmo = 0;
  logic [31:0] mdl_scratch = '0;

  pcievdm_ingr_avmm_adapter #(
    .INGR_SLV_ADDR_WIDTH (9),
    .INGR_SLV_CSR_AWIDTH (4),
    .RD_TIMEOUT_CYCLES   (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_addr    (s_addr),
    .s_write   (s_write),
    .s_read    (s_read),
    .s_byteen  (s_byteen),
    .s_wrdata  (s_wrdata),
    .s_rddata  (s_rddata),
    .s_rddvld  (s_rddvld),
    .s_waitreq (s_waitreq),
    .m_addr    (m_addr),
    .m_write   (m_write),
    .m_read    (m_read),
    .m_wrdata  (m_wrdata),
    .m_rddata  (m_rddata),
    .m_rddvld  (m_rddvld),
    .m_waitreq (m_waitreq)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] csr_exp(input logic [1:0] w);
    case (w)
      2'd0:    return 32'h0001_0000;
      2'd1:    return {16'h0, 8'(mdl_tmo), 8'(mdl_rej)};
      2'd2:    return mdl_scratch;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_waitreq"}, 32'(s_waitreq), 32'h0);
    chk({tag, "_rddvld"},  32'(s_rddvld), 32'h0);
    chk({tag, "_rddata"},  s_rddata, 32'h0);
    chk({tag, "_maddr"},   32'(m_addr), 32'h0);
    chk({tag, "_mwrite"},  32'(m_write), 32'h0);
    chk({tag, "_mread"},   32'(m_read), 32'h0);
    chk({tag, "_mwrdata"}, m_wrdata, 32'h0);
  endtask

  // One complete upstream transaction with the bench acting as downstream slave.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] data, input int stalls, input int lat);
    bit rej, csr;
    logic [8:0]  w;
    logic [31:0] exp;
    rej = (be != 4'hF) || (rd && wr);
    csr = (addr[31:4] == 28'h0);
    w = addr[10:2];
    chk("idle_waitreq", 32'(s_waitreq), 32'h0);
    s_read = rd; s_write = wr; s_addr = addr; s_byteen = be; s_wrdata = data;
    step();
    s_read = 1'b0; s_write = 1'b0; s_addr = $urandom; s_byteen = 4'($urandom); s_wrdata = $urandom;
    if (rej || csr) begin
      exp = rej ? 32'hFFFF_FFFF : csr_exp(addr[3:2]);
      if (rej && mdl_rej < 255) mdl_rej++;
      chk("local_mwrite", 32'(m_write), 32'h0);
      chk("local_mread", 32'(m_read), 32'h0);
      if (rd) begin
        chk("local_rddvld", 32'(s_rddvld), 32'h1);
        chk("local_rddata", s_rddata, exp);
        chk("local_waitreq", 32'(s_waitreq), 32'h1);
        step();
        chk("local_rddvld_end", 32'(s_rddvld), 32'h0);
      end else begin
        if (!rej && addr[3:2] == 2'd1) begin mdl_rej = 0; mdl_tmo = 0; end
        if (!rej && addr[3:2] == 2'd2) mdl_scratch = data;
        chk("lwr_rddvld", 32'(s_rddvld), 32'h0);
      end
      chk("local_done_waitreq", 32'(s_waitreq), 32'h0);
    end else begin
      for (int i = 0; i <= stalls; i++) begin
        m_waitreq = (i < stalls);
        m_rddvld = 1'($urandom_range(0, 1));
        m_rddata = $urandom;
        chk("cmd_mwrite", 32'(m_write), 32'(wr));
        chk("cmd_mread", 32'(m_read), 32'(rd));
        chk("cmd_maddr", 32'(m_addr), 32'(w));
        if (wr) chk("cmd_mwrdata", m_wrdata, data);
        chk("cmd_waitreq", 32'(s_waitreq), 32'h1);
        step();
      end
      m_waitreq = 1'($urandom_range(0, 1));
      m_rddvld = 1'b0;
      chk("post_mwrite", 32'(m_write), 32'h0);
      chk("post_mread", 32'(m_read), 32'h0);
      if (wr) begin
        mem[w] = data;
        chk("wr_done_waitreq", 32'(s_waitreq), 32'h0);
        chk("wr_rddvld", 32'(s_rddvld), 32'h0);
      end else begin
        for (int i = 0; i < lat; i++) begin
          chk("rd_wait_rddvld", 32'(s_rddvld), 32'h0);
          chk("rd_wait_waitreq", 32'(s_waitreq), 32'h1);
          step();
        end
        m_rddvld = 1'b1; m_rddata = mem[w];
        step();
        m_rddvld = 1'b0; m_rddata = $urandom;
        chk("rd_rddvld", 32'(s_rddvld), 32'h1);
        chk("rd_rddata", s_rddata, mem[w]);
        step();
        chk("rd_rddvld_end", 32'(s_rddvld), 32'h0);
        chk("rd_done_waitreq", 32'(s_waitreq), 32'h0);
      end
    end
  endtask

  initial begin
    bit rd, wr;
    int kind;
    logic [31:0] addr;
    logic [3:0]  be;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[9'h011] = 32'hA5A5_0001;

    repeat (3) step();
    chk_all_zero("reset");
    reset_n = 1'b1;
    step();

    // Stalled downstream write, then read with latency.
    txn(1'b0, 1'b1, 32'h0000_0040, 4'hF, 32'h1234_5678, 3, 0);
    txn(1'b1, 1'b0, 32'h0000_0044, 4'hF, 32'h0, 0, 4);
    // Rejections and CSR region.
    txn(1'b0, 1'b1, 32'h0000_0040, 4'h3, 32'h5555_AAAA, 0, 0);
    txn(1'b1, 1'b0, 32'h0000_0040, 4'h1, 32'h0, 0, 0);
    txn(1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 0, 0);
    txn(1'b1, 1'b1, 32'h0000_0040, 4'hF, 32'h0, 0, 0);
    txn(1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0, 0, 0);
    txn(1'b0, 1'b1, 32'h0000_0000, 4'hF, 32'h1111_2222, 0, 0);
    txn(1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0, 0, 0);
    txn(1'b0, 1'b1, 32'h0000_0008, 4'hF, 32'hCAFE_F00D, 0, 0);
    txn(1'b1, 1'b0, 32'h0000_0008, 4'hF, 32'h0, 0, 0);
    txn(1'b1, 1'b0, 32'h0000_000C, 4'hF, 32'h0, 0, 0);
    txn(1'b0, 1'b1, 32'h0000_0004, 4'hF, 32'h0, 0, 0);
    txn(1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 0, 0);
    txn(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0, 2, 1);

    // Reject counter saturation, then clear.
    for (int i = 0; i < 260; i++) txn(1'b0, 1'b1, 32'h0000_0080, 4'h0, $urandom, 0, 0);
    txn(1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 0, 0);
    txn(1'b0, 1'b1, 32'h0000_0004, 4'hF, 32'h0, 0, 0);

`ifdef PCIEVDM_INGR_RD_TIMEOUT_EN
    s_read = 1'b1; s_addr = 32'h0000_0048; s_byteen = 4'hF;
    step();
    s_read = 1'b0; m_waitreq = 1'b0; m_rddvld = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("tmo_wait_rddvld", 32'(s_rddvld), 32'h0);
      step();
    end
    chk("tmo_rddvld", 32'(s_rddvld), 32'h1);
    chk("tmo_rddata", s_rddata, 32'hDEAD_BEEF);
    if (mdl_tmo < 255) mdl_tmo++;
    step();
    m_rddvld = 1'b1; m_rddata = 32'h0BAD_0BAD;
    step();
    m_rddvld = 1'b0;
    chk("tmo_late_rddvld", 32'(s_rddvld), 32'h0);
    txn(1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 0, 0);
`else
    txn(1'b1, 1'b0, 32'h0000_0048, 4'hF, 32'h0, 1, 300);
    txn(1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 0, 0);
`endif

    // Reset while waiting for read data.
    s_read = 1'b1; s_addr = 32'h0000_0050; s_byteen = 4'hF;
    step();
    s_read = 1'b0; m_waitreq = 1'b0; m_rddvld = 1'b0;
    step();
    step();
    chk("wait_rd_waitreq", 32'(s_waitreq), 32'h1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    mdl_rej = 0; mdl_tmo = 0; mdl_scratch = '0;
    step();
    m_rddvld = 1'b1; m_rddata = 32'h7777_7777;
    reset_n = 1'b1;
    step();
    m_rddvld = 1'b0;
    chk("rst_spurious_rddvld0", 32'(s_rddvld), 32'h0);
    step();
    chk("rst_spurious_rddvld1", 32'(s_rddvld), 32'h0);
    txn(1'b1, 1'b0, 32'h0000_0008, 4'hF, 32'h0, 0, 0);
    txn(1'b1, 1'b0, 32'h0000_0050, 4'hF, 32'h0, 1, 2);

    // Randomized mix of data, CSR, and rejected commands.
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 9);
      rd = (kind >= 1 && kind <= 4) || kind == 0;
      wr = (kind >= 5) || kind == 0;
      if ($urandom_range(0, 2) == 0) begin
        addr = 32'($urandom_range(0, 15));
      end else if ($urandom_range(0, 1) == 0) begin
        addr = 32'h40 + 32'(4 * $urandom_range(0, 15));
      end else begin
        addr = $urandom;
        if (addr[31:4] == 28'h0) addr = addr | 32'h100;
      end
      be = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      txn(rd, wr, addr, be, $urandom, $urandom_range(0, 3), $urandom_range(0, 6));
    end
    txn(1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
